gemm_feeder: RTL
================

Name: gemm_feeder

Overview:
- Operand feeder directly upstream of the systolic PE array.
- Accepts one K-step of operands per beat: a column of A (ROWS values) and a row of B (COLS values), over a valid/ready handshake.
- Skews the operands into the triangular wavefront the array needs: row i delayed i steps, column j delayed j steps.
- Drives the array-wide en/clear_acc, flushes the pipeline after the last beat, and pulses done when every PE accumulator holds its final sum.

Parameters:
- ROWS, 4, PE array rows (A lanes).
- COLS, 4, PE array columns (B lanes).
- DATA_W, 8, signed operand width.
- K_W, 16, width of the reduction-length field.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  launch job; sampled only in IDLE.
- k_len  in  K_W  reduction length; captured on start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; accumulators final.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  high only in STREAM.
- a_vec  in  ROWS*DATA_W  A lanes, lane i at bits [i*DATA_W +: DATA_W].
- b_vec  in  COLS*DATA_W  B lanes, same packing.
- a_edge  out  ROWS*DATA_W  to PE west edge, row i.
- b_edge  out  COLS*DATA_W  to PE north edge, column j.
- pe_en  out  1  array-wide en.
- pe_clear  out  1  array-wide clear_acc.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all skew registers=0.
  - busy, done, in_ready, pe_en, pe_clear = 0.
  - a_edge, b_edge = 0; beat and flush counters = 0.
  - Reset mid-job abandons the job silently, with no done.
- States: IDLE -> CLEAR -> STREAM -> FLUSH -> DONE -> IDLE.
- IDLE: start=1 captures k_len and goes to CLEAR.
- CLEAR (1 cycle): pe_clear=1, pe_en=0.
  - Skew registers synchronously zeroed.
  - Next state is STREAM if k_len>0, else DONE.
- STREAM:
  - in_ready=1; a beat is accepted when in_valid&in_ready.
  - pe_en = in_valid (combinational); a stall cycle freezes the whole array and all skew lines.
  - On the K-th accepted beat, go to FLUSH if ROWS+COLS-2>0, else DONE.
- FLUSH:
  - in_ready=0, pe_en=1; lanes are fed zeros.
  - Lasts exactly ROWS+COLS-2 cycles, then DONE.
- DONE (1 cycle): done=1, pe_en=0, busy=1, then IDLE.
- Skew lines:
  - Lane i (A) or j (B) is a shift register of depth i (j) that advances only when pe_en=1.
  - a_edge[i] = the A input from i advances earlier; lane 0 has depth 0 and is combinational from a_vec (zero during FLUSH).
  - Same rule for b_edge[j].
  - a_edge/b_edge values are don't-care while pe_en=0; the bench checks them only when pe_en=1.
- Latency with no stalls, counting cycles after the start edge:
  - CLEAR at cycle 1.
  - STREAM at cycles 2..K+1.
  - FLUSH at cycles K+2..K+ROWS+COLS-1.
  - done at cycle K+ROWS+COLS.
  - Each stall cycle adds one.
- start while busy is ignored; no queueing.
- k_len is latched, so changes to the k_len input during a job have no effect.
- in_valid outside STREAM is ignored; no beat is consumed.
- Values pass through unmodified; no arithmetic on data.
- Counters are K_W wide and do not wrap because the STREAM exit compares against the latched k_len.

Decomposition:
- Package gemm_pkg holds:
  - feeder_state_t enum (IDLE, CLEAR, STREAM, FLUSH, DONE).
  - localparam/function flush_len(ROWS, COLS) = ROWS+COLS-2.
  - The lane slicing helper.
- One sub-module, skew_line: parameters DEPTH and DATA_W; ports en and sync clr.
  - DEPTH=0 degenerates to a wire.
  - Instantiated once per A lane and per B lane via generate.

Test Plan:
1. 4x4, k_len=1, a_vec=[1,2,3,4], b_vec=[5,6,7,8], in_valid held high -> done exactly at cycle 9 after start; in the 4x4 PE model, acc[i][j]=a_i*b_j (e.g. acc[3][3]=32); busy falls the cycle after done.
2. k_len=4, random signed operands, in_valid pattern 1,0,0,1,1,0,1 -> pe_en mirrors in_valid in STREAM; accumulators match the golden A*B; done at cycle 4+8+3 stalls = 15.
3. k_len=8, all lanes -128 -> every acc = 131072; a_edge[3] equals beat n exactly 3 advances later.
4. k_len=0 -> pe_clear at cycle 1, done at cycle 2, no pe_en ever, accs = 0.
5. rst pulsed mid-STREAM after 2 beats -> busy, in_ready, pe_en, edges = 0 immediately; no done; a new start then completes a correct job.
6. start asserted during FLUSH, then back-to-back jobs -> mid-job start ignored; the second job's pe_clear occurs after the first done, and both results are correct.

Source files
------------

// File: rtl/gemm_pkg.sv
// gemm_pkg: shared types and helpers for the GEMM operand feeder.
//   feeder_state_t : sequencer states (IDLE, CLEAR, STREAM, FLUSH, DONE)
//   flush_len      : number of zero-fed cycles needed to drain the array
//   lane_lsb       : bit offset of a lane inside a packed lane vector
package gemm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        FLUSH,
        DONE
    } feeder_state_t;

    // The last operand must skew through ROWS-1 (or COLS-1) delay stages and
    // then hop across the remaining PEs before it reaches the far corner.
    function automatic int flush_len(input int rows, input int cols);
        return rows + cols - 2;
    endfunction

    function automatic int lane_lsb(input int lane, input int data_w);
        return lane * data_w;
    endfunction

endpackage

// File: rtl/gemm_feeder_if.sv
// gemm_feeder_if: operand beat stream into the feeder.
//   in_valid : beat valid (master -> slave)
//   in_ready : feeder can take a beat (slave -> master)
//   a_vec    : ROWS A lanes, lane i at [i*DATA_W +: DATA_W]
//   b_vec    : COLS B lanes, same packing
interface gemm_feeder_if #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 8
);

    logic                     in_valid;
    logic                     in_ready;
    logic [ROWS*DATA_W-1:0]   a_vec;
    logic [COLS*DATA_W-1:0]   b_vec;

    modport master (
        output in_valid,
        output a_vec,
        output b_vec,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  a_vec,
        input  b_vec,
        output in_ready
    );

endinterface

// File: rtl/gemm_feeder_skew_line.sv
// skew_line: enable-gated delay line of DEPTH stages for one operand lane.
//   clk, rst : clock, asynchronous active-high reset
//   en       : advance the line by one stage
//   clr      : synchronous clear of every stage (wins over en)
//   din      : lane input
//   dout     : lane input from DEPTH advances earlier (DEPTH=0 is a wire)
module skew_line #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            // No storage: the control inputs are intentionally left unused.
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst, en, clr};
            assign dout = din;
        end else begin : g_shift
            logic [DATA_W-1:0] taps [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < DEPTH; k++) taps[k] <= '0;
                end else if (clr) begin
                    for (int k = 0; k < DEPTH; k++) taps[k] <= '0;
                end else if (en) begin
                    taps[0] <= din;
                    for (int k = 1; k < DEPTH; k++) taps[k] <= taps[k-1];
                end
            end

            assign dout = taps[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/gemm_feeder.sv
// gemm_feeder: operand feeder in front of a ROWS x COLS systolic PE array.
//   clk, rst         : clock, asynchronous active-high reset
//   start, k_len     : launch a job of k_len beats (sampled in IDLE only)
//   busy, done       : job in progress / one-cycle completion pulse
//   in_bus (slave)   : in_valid/in_ready handshake carrying a_vec, b_vec
//   a_edge, b_edge   : skewed operands to the PE west / north edges
//   pe_en, pe_clear  : array-wide enable and accumulator clear
module gemm_feeder
    import gemm_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 8,
    parameter int K_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [K_W-1:0]         k_len,
    output logic                   busy,
    output logic                   done,
    gemm_feeder_if.slave           in_bus,
    output logic [ROWS*DATA_W-1:0] a_edge,
    output logic [COLS*DATA_W-1:0] b_edge,
    output logic                   pe_en,
    output logic                   pe_clear
);

    localparam int FLUSH_LEN = flush_len(ROWS, COLS);

    feeder_state_t  state;
    feeder_state_t  state_nxt;
    logic [K_W-1:0] k_reg;
    logic [K_W-1:0] beat_cnt;
    logic [K_W-1:0] flush_cnt;
    logic           accept;
    logic           last_beat;
    logic           flush_last;
    logic           lane_live;

    assign accept     = (state == STREAM) && in_bus.in_valid;
    // Only reached with k_reg > 0, so k_reg - 1 never wraps here.
    assign last_beat  = accept && (beat_cnt == k_reg - K_W'(1));
    assign flush_last = (flush_cnt == K_W'(FLUSH_LEN - 1));
    // Lanes see real data only while streaming; otherwise zeros, which keeps
    // the depth-0 lanes quiet outside STREAM and drains the array in FLUSH.
    assign lane_live  = (state == STREAM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CLEAR;
            CLEAR:   state_nxt = (k_reg != '0) ? STREAM : DONE;
            STREAM:  if (last_beat) state_nxt = (FLUSH_LEN > 0) ? FLUSH : DONE;
            FLUSH:   if (flush_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy            = (state != IDLE);
        done            = (state == DONE);
        in_bus.in_ready = (state == STREAM);
        pe_clear        = (state == CLEAR);
        pe_en           = 1'b0;
        case (state)
            STREAM:  pe_en = in_bus.in_valid;
            FLUSH:   pe_en = 1'b1;
            default: pe_en = 1'b0;
        endcase
    end

    // Job length is latched on start so the k_len input may change freely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_reg     <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            if (state == IDLE && start) k_reg <= k_len;

            if (state == CLEAR)  beat_cnt <= '0;
            else if (accept)     beat_cnt <= beat_cnt + K_W'(1);

            if (state == FLUSH)  flush_cnt <= flush_cnt + K_W'(1);
            else                 flush_cnt <= '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_a_lane
            logic [DATA_W-1:0] lane_in;
            assign lane_in = lane_live ? in_bus.a_vec[lane_lsb(gi, DATA_W) +: DATA_W] : '0;
            skew_line #(.DEPTH(gi), .DATA_W(DATA_W)) u_skew (
                .clk  (clk),
                .rst  (rst),
                .en   (pe_en),
                .clr  (pe_clear),
                .din  (lane_in),
                .dout (a_edge[lane_lsb(gi, DATA_W) +: DATA_W])
            );
        end
        for (gi = 0; gi < COLS; gi++) begin : g_b_lane
            logic [DATA_W-1:0] lane_in;
            assign lane_in = lane_live ? in_bus.b_vec[lane_lsb(gi, DATA_W) +: DATA_W] : '0;
            skew_line #(.DEPTH(gi), .DATA_W(DATA_W)) u_skew (
                .clk  (clk),
                .rst  (rst),
                .en   (pe_en),
                .clr  (pe_clear),
                .din  (lane_in),
                .dout (b_edge[lane_lsb(gi, DATA_W) +: DATA_W])
            );
        end
    endgenerate

endmodule
